// File: rtl/hdlc_tx_sequencer_pkg.sv
// Shared HDLC transmit definitions: sequencer state encoding, flag and abort
// bit patterns (both sent bit0 first) and default framing parameters.
package hdlc_tx_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START_FLAG,
      ST_DATA,
      ST_END_FLAG,
      ST_ABORT,
      ST_GAP
   } tx_state_t;

   localparam logic [7:0] FLAG_PAT        = 8'b0111_1110;
   localparam logic [7:0] ABORT_PAT       = 8'b1111_1110;
   localparam int         STUFF_LIMIT_DEF = 5;
   localparam int         MIN_IDLE_DEF    = 8;

endpackage

// File: rtl/hdlc_tx_sequencer_if.sv
// Tx buffer / serial-line bundle of the HDLC transmit sequencer.
//   master : buffer/host side - drives TxEN and the FWFT head byte, abort request
//   slave  : sequencer side   - drives Tx, pop strobe, busy and status pulses
interface hdlc_tx_sequencer_if;
   logic       TxEN;
   logic       Tx_DataValid;
   logic [7:0] Tx_Data;
   logic       Tx_DataLast;
   logic       Tx_AbortFrame;
   logic       Tx;
   logic       Tx_DataRd;
   logic       Tx_Busy;
   logic       Tx_Done;
   logic       Tx_AbortedTrans;
   logic       Tx_Underrun;

   modport master (
      output TxEN, Tx_DataValid, Tx_Data, Tx_DataLast, Tx_AbortFrame,
      input  Tx, Tx_DataRd, Tx_Busy, Tx_Done, Tx_AbortedTrans, Tx_Underrun
   );

   modport slave (
      input  TxEN, Tx_DataValid, Tx_Data, Tx_DataLast, Tx_AbortFrame,
      output Tx, Tx_DataRd, Tx_Busy, Tx_Done, Tx_AbortedTrans, Tx_Underrun
   );
endinterface

// File: rtl/hdlc_tx_sequencer_stuffer.sv
// Zero-bit-insertion tracker. Counts consecutive data ones driven on the line.
//   Clk, Rst      : clock, asynchronous active-high reset
//   clr_i         : break the run (flags, abort, idle)
//   load_i, bit_i : a data or stuffed bit is being loaded onto the line
//   stuff_now_o   : the bit currently on the line completed a run; next must be 0
//   stuff_req_o   : loading bit_i will complete a run (look-ahead for byte end)
module hdlc_bit_stuffer #(
   parameter int STUFF_LIMIT = 5
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clr_i,
   input  logic load_i,
   input  logic bit_i,
   output logic stuff_now_o,
   output logic stuff_req_o
);

   logic [2:0] ones_q;

   assign stuff_now_o = (ones_q == 3'(STUFF_LIMIT));
   assign stuff_req_o = bit_i && (({1'b0, ones_q} + 4'd1) == 4'(STUFF_LIMIT));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ones_q <= 3'd0;
      end else if (load_i) begin
         ones_q <= bit_i ? ones_q + 3'd1 : 3'd0;
      end else if (clr_i) begin
         ones_q <= 3'd0;
      end
   end

endmodule

// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit sequencer: idle ones, start flag, LSB-first data with zero-bit
// insertion, then end flag or abort pattern, followed by a forced idle gap.
//   Clk, Rst : clock, asynchronous active-high reset (Tx forced to 1)
//   bus      : slave side of hdlc_tx_sequencer_if (FWFT buffer in, serial/status out)
// All outputs are registered; the registers hold the bit currently on the line.
module hdlc_tx_sequencer
   import hdlc_tx_sequencer_pkg::*;
#(
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF,
   parameter int MIN_IDLE    = MIN_IDLE_DEF
) (
   input logic               Clk,
   input logic               Rst,
   hdlc_tx_sequencer_if.slave bus
);

   localparam int GAP_W = (MIN_IDLE < 2) ? 1 : $clog2(MIN_IDLE + 1);

   tx_state_t  state_q;
   logic [2:0] bit_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic       byte_end_q;   // bit on the line is the final cycle of a byte
   logic       upend_q;      // underrun flagged; abort after the final cycle
   logic       tx_q, rd_q, busy_q, done_q, abt_q, unr_q;
   logic [7:0] shreg_q;
   logic       last_q;

   logic [2:0] nxt_idx;
   logic       abort_req, load_byte, st_load, st_bit, stuff_now, stuff_req;
   logic       boundary, need_pop, uflow;

   always_comb begin
      nxt_idx   = bit_cnt_q + 3'd1;
      abort_req = bus.Tx_AbortFrame &&
                  (state_q == ST_START_FLAG || state_q == ST_DATA);
      load_byte = !abort_req &&
                  ((state_q == ST_START_FLAG && bit_cnt_q == 3'd7) ||
                   (state_q == ST_DATA && byte_end_q && !last_q && !upend_q));
      st_bit    = 1'b0;
      if (load_byte)
         st_bit = bus.Tx_Data[0];
      else if (state_q == ST_DATA && !byte_end_q && !stuff_now)
         st_bit = shreg_q[nxt_idx];
      st_load   = load_byte ||
                  (state_q == ST_DATA && !abort_req && !byte_end_q);
      // The byte ends on bit7 unless bit7 completes a run, in which case the
      // stuffed zero that follows becomes the byte's final cycle.
      boundary  = (state_q == ST_DATA) && !byte_end_q &&
                  (stuff_now ? (bit_cnt_q == 3'd7)
                             : (nxt_idx == 3'd7 && !stuff_req));
      need_pop  = boundary && !last_q;
      uflow     = need_pop && !bus.Tx_DataValid;
   end

   // Any cycle that does not put a data or stuffed bit on the line breaks the run.
   hdlc_bit_stuffer #(.STUFF_LIMIT(STUFF_LIMIT)) u_stuffer (
      .Clk         (Clk),
      .Rst         (Rst),
      .clr_i       (!st_load),
      .load_i      (st_load),
      .bit_i       (st_bit),
      .stuff_now_o (stuff_now),
      .stuff_req_o (stuff_req)
   );

   always_ff @(posedge Clk) begin
      if (load_byte) begin
         shreg_q <= bus.Tx_Data;
         last_q  <= bus.Tx_DataLast;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         gap_cnt_q  <= '0;
         byte_end_q <= 1'b0;
         upend_q    <= 1'b0;
         tx_q       <= 1'b1;
         rd_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abt_q      <= 1'b0;
         unr_q      <= 1'b0;
      end else begin
         rd_q  <= 1'b0;
         done_q <= 1'b0;
         abt_q <= 1'b0;
         unr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.TxEN && bus.Tx_DataValid && gap_cnt_q == '0) begin
                  state_q   <= ST_START_FLAG;
                  tx_q      <= FLAG_PAT[0];
                  bit_cnt_q <= 3'd0;
                  busy_q    <= 1'b1;
               end
            end
            ST_START_FLAG, ST_DATA: begin
               if (abort_req) begin
                  // Bit in flight completes; a pending stuff bit is dropped.
                  state_q    <= ST_ABORT;
                  tx_q       <= ABORT_PAT[0];
                  bit_cnt_q  <= 3'd0;
                  byte_end_q <= 1'b0;
                  upend_q    <= 1'b0;
                  unr_q      <= uflow;
               end else if (load_byte) begin
                  state_q    <= ST_DATA;
                  tx_q       <= bus.Tx_Data[0];
                  bit_cnt_q  <= 3'd0;
                  byte_end_q <= 1'b0;
               end else if (state_q == ST_START_FLAG) begin
                  tx_q      <= FLAG_PAT[nxt_idx];
                  bit_cnt_q <= nxt_idx;
                  rd_q      <= (nxt_idx == 3'd7);
               end else if (byte_end_q) begin
                  byte_end_q <= 1'b0;
                  upend_q    <= 1'b0;
                  bit_cnt_q  <= 3'd0;
                  if (last_q) begin
                     state_q <= ST_END_FLAG;
                     tx_q    <= FLAG_PAT[0];
                  end else begin
                     state_q <= ST_ABORT;
                     tx_q    <= ABORT_PAT[0];
                  end
               end else begin
                  if (stuff_now) begin
                     tx_q <= 1'b0;
                  end else begin
                     tx_q      <= shreg_q[nxt_idx];
                     bit_cnt_q <= nxt_idx;
                  end
                  if (boundary) begin
                     byte_end_q <= 1'b1;
                     if (need_pop) begin
                        rd_q    <= !uflow;
                        unr_q   <= uflow;
                        upend_q <= uflow;
                     end
                  end
               end
            end
            ST_END_FLAG, ST_ABORT: begin
               if (bit_cnt_q == 3'd7) begin
                  tx_q      <= 1'b1;
                  done_q    <= (state_q == ST_END_FLAG);
                  abt_q     <= (state_q == ST_ABORT);
                  bit_cnt_q <= 3'd0;
                  if (MIN_IDLE == 0) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q   <= ST_GAP;
                     gap_cnt_q <= GAP_W'(MIN_IDLE > 0 ? MIN_IDLE - 1 : 0);
                  end
               end else begin
                  bit_cnt_q <= nxt_idx;
                  tx_q      <= (state_q == ST_END_FLAG) ? FLAG_PAT[nxt_idx]
                                                        : ABORT_PAT[nxt_idx];
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == '0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.Tx              = tx_q;
   assign bus.Tx_DataRd       = rd_q;
   assign bus.Tx_Busy         = busy_q;
   assign bus.Tx_Done         = done_q;
   assign bus.Tx_AbortedTrans = abt_q;
   assign bus.Tx_Underrun     = unr_q;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Bench for hdlc_tx_sequencer: FWFT buffer model, per-cycle expected line
// stream queued when each frame is launched and compared as the DUT runs.
module tb_hdlc_tx_sequencer;

   typedef struct packed {
      logic tx;
      logic rd;
      logic busy;
      logic done;
      logic abt;
      logic unr;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hdlc_tx_sequencer_if bus ();
   hdlc_tx_sequencer dut (.Clk(clk), .Rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;
   obs_t exp_q[$];
   logic [8:0] buf_q[$];
   logic [7:0] fb[4];
   logic [7:0] flag_v  = 8'b0111_1110;
   logic [7:0] abort_v = 8'b1111_1110;
   int m_idx;
   int abort_k;

   function automatic obs_t mk(logic tx, logic rd, logic busy, logic done,
                               logic abt, logic unr);
      obs_t e;
      e = '{tx: tx, rd: rd, busy: busy, done: done, abt: abt, unr: unr};
      return e;
   endfunction

   function automatic obs_t sample();
      return mk(bus.Tx, bus.Tx_DataRd, bus.Tx_Busy, bus.Tx_Done,
                bus.Tx_AbortedTrans, bus.Tx_Underrun);
   endfunction

   task automatic chk(input string tag, input int idx, input obs_t o, input obs_t e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s[%0d] observed={tx,rd,busy,done,abt,unr}=%b expected=%b",
                tag, idx, o, e);
      end
   endtask

   task automatic drive_buf();
      bus.Tx_DataValid = (buf_q.size() > 0);
      bus.Tx_Data      = (buf_q.size() > 0) ? buf_q[0][7:0] : 8'h00;
      bus.Tx_DataLast  = (buf_q.size() > 0) ? buf_q[0][8] : 1'b0;
   endtask

   // Expected line stream of one frame: idle cycle, flag, stuffed data,
   // then end flag (or abort pattern), idle gap and one idle cycle.
   task automatic model_frame(input int n, input bit ends_last, input int abort_at);
      obs_t seq[$];
      obs_t e;
      int ones;
      logic b;
      logic [7:0] pat;
      bit aborted;
      ones = 0;
      seq.push_back(mk(1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++) seq.push_back(mk(flag_v[i], i == 7, 1, 0, 0, 0));
      for (int bi = 0; bi < n; bi++) begin
         for (int i = 0; i < 8; i++) begin
            b = fb[bi][i];
            seq.push_back(mk(b, 0, 1, 0, 0, 0));
            ones = b ? ones + 1 : 0;
            if (ones == 5) begin
               seq.push_back(mk(0, 0, 1, 0, 0, 0));
               ones = 0;
            end
         end
         e = seq.pop_back();
         if (bi < n - 1) e.rd = 1'b1;
         else if (!ends_last) e.unr = 1'b1;
         seq.push_back(e);
      end
      if (abort_at >= 0)
         while (seq.size() > abort_at + 1) void'(seq.pop_back());
      aborted = (abort_at >= 0) || !ends_last;
      pat = aborted ? abort_v : flag_v;
      for (int i = 0; i < 8; i++) seq.push_back(mk(pat[i], 0, 1, 0, 0, 0));
      for (int i = 0; i < 8; i++)
         seq.push_back(mk(1, 0, 1, (i == 0) && !aborted, (i == 0) && aborted, 0));
      seq.push_back(mk(1, 0, 0, 0, 0, 0));
      foreach (seq[i]) exp_q.push_back(seq[i]);
   endtask

   task automatic tick();
      obs_t o;
      obs_t e;
      logic rd_seen;
      @(negedge clk);
      o = sample();
      rd_seen = bus.Tx_DataRd;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("line", m_idx, o, e);
         m_idx++;
      end
      @(posedge clk);
      #1;
      if (rd_seen && buf_q.size() > 0) void'(buf_q.pop_front());
      drive_buf();
      bus.Tx_AbortFrame = (abort_k >= 0) && (m_idx == abort_k);
   endtask

   task automatic start_frame(input int n, input bit ends_last, input int abort_at);
      for (int i = 0; i < n; i++) buf_q.push_back({ends_last && (i == n - 1), fb[i]});
      m_idx   = 0;
      abort_k = abort_at;
      drive_buf();
      model_frame(n, ends_last, abort_at);
   endtask

   task automatic run(input int budget);
      int c;
      c = 0;
      while (exp_q.size() > 0 && c < budget) begin
         tick();
         c++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $error("FAIL timeout pending=%0d observed_cycles=%0d required_below=%0d",
                exp_q.size(), c, budget);
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.TxEN = 1'b0;
      bus.Tx_AbortFrame = 1'b0;
      m_idx = 0;
      abort_k = -1;
      drive_buf();
      #3;
      chk("reset", 0, sample(), mk(1, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.TxEN = 1'b1;

      // Reset mid-frame: line returns to 1 at once, all strobes low.
      buf_q.push_back({1'b1, 8'hFF});
      drive_buf();
      for (int i = 0; i < 14; i++) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", 0, sample(), mk(1, 0, 0, 0, 0, 0));
      buf_q.delete();
      drive_buf();
      @(posedge clk);
      #1;
      chk("rst_held", 0, sample(), mk(1, 0, 0, 0, 0, 0));
      rst = 1'b0;

      // Single zero byte, restart after reset.
      fb[0] = 8'h00;
      start_frame(1, 1'b1, -1);
      run(200);

      // 0xFF: one stuffed zero; TxEN dropped mid-frame, frame still completes.
      fb[0] = 8'hFF;
      start_frame(1, 1'b1, -1);
      for (int i = 0; i < 6; i++) tick();
      bus.TxEN = 1'b0;
      run(200);
      bus.TxEN = 1'b1;

      // Stuffing at the last byte's end, before the end flag.
      fb[0] = 8'h1F;
      fb[1] = 8'hF8;
      start_frame(2, 1'b1, -1);
      run(200);

      // Stuffing at a non-last byte end: pop moves to the stuffed cycle.
      fb[0] = 8'hF8;
      fb[1] = 8'h01;
      start_frame(2, 1'b1, -1);
      run(200);

      // Abort during the second byte.
      fb[0] = 8'hA5;
      fb[1] = 8'h3C;
      start_frame(2, 1'b1, 19);
      run(200);
      abort_k = -1;

      // Underrun at the second-byte fetch.
      fb[0] = 8'h55;
      start_frame(1, 1'b0, -1);
      run(200);

      // Three bytes back-to-back after the gap.
      fb[0] = 8'h7E;
      fb[1] = 8'hBF;
      fb[2] = 8'hFC;
      start_frame(3, 1'b1, -1);
      run(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
